// File: rtl/dmem_responder_pkg.sv
// Shared constants and types for the data-side memory responder.
// Holds the MMIO address map, the load/store size encodings, the serializer
// state type and the load extension helper.
package dmem_responder_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ALEN = 32;

    localparam logic [ALEN-1:0] MMIO_BASE      = 32'h8000_0000;
    localparam logic [ALEN-1:0] LED_ADDR       = 32'h8000_0000;
    localparam logic [ALEN-1:0] UART_DATA_ADDR = 32'h8000_0004;
    localparam logic [ALEN-1:0] UART_STAT_ADDR = 32'h8000_0008;

    // funct3[1:0] gives the size; funct3[2] marks an unsigned load.
    localparam logic [2:0] F3_BYTE = 3'b000;
    localparam logic [2:0] F3_HALF = 3'b001;
    localparam logic [2:0] F3_WORD = 3'b010;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    // Select the addressed byte/half of a word and sign or zero extend it.
    function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] w,
                                                    input logic [2:0]      f3,
                                                    input logic [1:0]      off);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (f3[1:0])
            F3_BYTE[1:0]: return f3[2] ? {24'b0, b} : {{24{b[7]}}, b};
            F3_HALF[1:0]: return f3[2] ? {16'b0, h} : {{16{h[15]}}, h};
            default:      return w;
        endcase
    endfunction

endpackage

// File: rtl/dmem_responder_uart_tx_serializer.sv
// 8N1 UART transmit serializer with a per-bit cycle timer.
// Ports: clk_i, rst_i (sync, active-high), data_i/valid_i byte offer,
// ready_c_o (byte accepted this cycle when valid_i), idle_c_o (FSM in IDLE),
// tx_o registered serial line, idle high.
module uart_tx_serializer
    import dmem_responder_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic       ready_c_o,
    output logic       idle_c_o,
    output logic       tx_o
);

    localparam int unsigned TW = $clog2(CLKS_PER_BIT);

    uart_state_t   state_q;
    logic [TW-1:0] tmr_q;
    logic [2:0]    bit_q;
    logic [7:0]    shreg_q;
    logic          tx_q;
    logic          bit_end;

    assign bit_end   = (tmr_q == TW'(CLKS_PER_BIT - 1));
    // Accepting at the end of STOP chains the next frame with no idle gap.
    assign ready_c_o = (state_q == IDLE) || (state_q == STOP && bit_end);
    assign idle_c_o  = (state_q == IDLE);
    assign tx_o      = tx_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (valid_i) begin
                        state_q <= START;
                        shreg_q <= data_i;
                        tmr_q   <= '0;
                        tx_q    <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        tmr_q   <= '0;
                        bit_q   <= '0;
                        state_q <= DATA;
                        tx_q    <= shreg_q[0];
                    end else begin
                        tmr_q <= tmr_q + TW'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        tmr_q <= '0;
                        if (bit_q == 3'd7) begin
                            state_q <= STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            shreg_q <= {1'b0, shreg_q[7:1]};
                            tx_q    <= shreg_q[1];
                        end
                    end else begin
                        tmr_q <= tmr_q + TW'(1);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        tmr_q <= '0;
                        if (valid_i) begin
                            state_q <= START;
                            shreg_q <= data_i;
                            tx_q    <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        tmr_q <= tmr_q + TW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-side memory responder: word RAM with byte-lane stores, registered
// extended loads, LED register and (with DMEM_UART_EN defined) a FIFO-buffered
// UART transmitter with status register.
// Ports: clk, rst (sync, active-high), dmem_addr/wdata/we/be/funct3 from the
// MEM stage, dmem_rdata load data one cycle later, leds_out, uart_tx.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS   = 4096,
    parameter int unsigned CLKS_PER_BIT  = 868,
    parameter int unsigned TX_FIFO_DEPTH = 4,
    parameter string       INIT_FILE     = ""
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [ALEN-1:0] dmem_addr,
    input  logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_we,
    input  logic [3:0]      dmem_be,
    input  logic [2:0]      dmem_funct3,
    output logic [XLEN-1:0] dmem_rdata,
    output logic [7:0]      leds_out,
    output logic            uart_tx
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    logic [XLEN-1:0] mem [DEPTH_WORDS];
    logic [AW-1:0]   idx;
    logic            is_ram, led_hit, stat_hit;
    logic [XLEN-1:0] lane;
    logic [XLEN-1:0] mmio_rd;
    logic [XLEN-1:0] stat_w;

    logic [XLEN-1:0] ram_q;
    logic [XLEN-1:0] mmio_q;
    logic            is_mmio_q;
    logic [2:0]      f3_q;
    logic [1:0]      off_q;
    logic [7:0]      leds_q;

    assign idx      = dmem_addr[AW+1:2];
    assign is_ram   = ~dmem_addr[31];
    assign led_hit  = (dmem_addr == LED_ADDR);
    assign stat_hit = (dmem_addr == UART_STAT_ADDR);

    // Sub-word stores arrive in the low bits and are shifted onto their lanes.
    assign lane = (dmem_funct3[1:0] == F3_WORD[1:0]) ? dmem_wdata
                                                     : dmem_wdata << {dmem_addr[1:0], 3'b000};

    // RAM: byte-lane write, unconditional read-first registered read.
    always_ff @(posedge clk) begin
        if (dmem_we && is_ram) begin
            for (int k = 0; k < 4; k++) begin
                if (dmem_be[k]) mem[idx][8*k +: 8] <= lane[8*k +: 8];
            end
        end
        ram_q <= mem[idx];
    end

    // MMIO read mux; UART_DATA and unmapped addresses read zero.
    always_comb begin
        mmio_rd = '0;
        if (led_hit)       mmio_rd = {24'b0, leds_q};
        else if (stat_hit) mmio_rd = stat_w;
    end

    // Load-side control and LED register. Reset selects the zeroed MMIO word.
    always_ff @(posedge clk) begin
        if (rst) begin
            mmio_q    <= '0;
            is_mmio_q <= 1'b1;
            f3_q      <= '0;
            off_q     <= '0;
            leds_q    <= '0;
        end else begin
            mmio_q    <= mmio_rd;
            is_mmio_q <= ~is_ram;
            f3_q      <= dmem_funct3;
            off_q     <= dmem_addr[1:0];
            if (dmem_we && led_hit) leds_q <= dmem_wdata[7:0];
        end
    end

    assign dmem_rdata = load_extend(is_mmio_q ? mmio_q : ram_q, f3_q, off_q);
    assign leds_out   = leds_q;

`ifdef DMEM_UART_EN
    localparam int unsigned PW = $clog2(TX_FIFO_DEPTH);

    logic [7:0]    fifo_q [TX_FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   count_q;
    logic          ovf_q;
    logic          data_hit, push_req, push, pop, full, empty;
    logic          ser_ready, ser_idle;

    assign data_hit = (dmem_addr == UART_DATA_ADDR);
    assign full     = (count_q == (PW+1)'(TX_FIFO_DEPTH));
    assign empty    = (count_q == '0);
    assign push_req = dmem_we && data_hit;
    assign pop      = ~empty && ser_ready;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign push     = push_req && (~full || pop);
    assign stat_w   = {29'b0, ovf_q, full, ~ser_idle | ~empty};

    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= dmem_wdata[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (PW+1)'(1);
                2'b01:   count_q <= count_q - (PW+1)'(1);
                default: count_q <= count_q;
            endcase
            if (push_req && full && ~pop) ovf_q <= 1'b1;
        end
    end

    uart_tx_serializer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_ser (
        .clk_i    (clk),
        .rst_i    (rst),
        .data_i   (fifo_q[rd_ptr_q]),
        .valid_i  (~empty),
        .ready_c_o(ser_ready),
        .idle_c_o (ser_idle),
        .tx_o     (uart_tx)
    );
`else
    assign stat_w  = '0;
    assign uart_tx = 1'b1;
`endif

endmodule
